otsu_sigmaw_argmin: RTL
=======================

// Module: otsu_sigmaw_argmin
// PURPOSE
//  Sequential successor to the combinational within-class variance stage of the Otsu path.
//  Per frame, accepts one (omega0, sigma0_sq, omega1, sigma1_sq) tuple per candidate threshold.
//  For each tuple, computes sigmaW_sq = omega0*sigma0_sq + omega1*sigma1_sq in a pipeline.
//  Tracks the minimum over NBINS candidates and reports the winning threshold with a done pulse.
//  Sits between the class-statistics generator and the binarisation stage.
// PARAMETERS
//  IW     16                 width of omega/sigma inputs (unsigned)
//  NBINS  256                candidate thresholds per frame (>=2)
//  TW     $clog2(NBINS)      threshold index width
//  OUTW   2*IW+1             sigmaW_sq width (two products plus carry bit)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     begin frame; sampled only in IDLE
//  in_valid     in   1     input tuple valid
//  in_ready     out  1     block accepts tuple (RUN only)
//  omega0       in   IW    class-0 weight
//  sigma0_sq    in   IW    class-0 variance
//  omega1       in   IW    class-1 weight
//  sigma1_sq    in   IW    class-1 variance
//  busy         out  1     high in RUN and DRAIN
//  done         out  1     one-cycle pulse when the result is final
//  found        out  1     at least one candidate was eligible this frame
//  best_thr     out  TW    index of minimum sigmaW_sq
//  best_sigmaW  out  OUTW  minimum sigmaW_sq value
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high.
//   On rst=1 at a rising edge:
//   - FSM goes to IDLE, index counter and pipeline valids clear.
//   - All outputs go to 0: in_ready, busy, done, found, best_thr, best_sigmaW.
//   - Reset during RUN or DRAIN aborts the frame; no done pulse is produced.
//  FSM:
//   - IDLE -> RUN on start.
//     Clears index k, found and the running minimum (min <= all-ones), and sets busy.
//   - RUN: in_ready=1. Accept when in_valid&&in_ready. Accepted beat gets index k, then k++.
//     After the NBINS-th accept: in_ready=0 in the next cycle, go to DRAIN.
//   - DRAIN: no accepts. Stay until all pipeline valids are 0, then go to DONE.
//   - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
//  In-flight beats and outputs:
//   - start outside IDLE is ignored. in_valid outside RUN is ignored (no accept).
//   - best_thr, best_sigmaW and found hold their last values from DONE until the next start.
//     On start they read the cleared state: found=0, best_thr=0, best_sigmaW=0.
//  Pipeline (3 stages, each tagged with valid and index):
//   S1: prod0=omega0*sigma0_sq, prod1=omega1*sigma1_sq, both 2*IW bits, registered.
//       S1 also registers elig = (omega0!=0)&&(omega1!=0).
//   S2: sum = {1'b0,prod0}+{1'b0,prod1}, OUTW bits, registered; never overflows.
//   S3: if valid&&elig&&(sum<min): min<=sum, best_thr<=idx, found<=1.
//  Ordering and ties:
//   - Latency from accept to comparison is 3 cycles.
//   - DONE is reached no earlier than 4 cycles after the last accept.
//   - Strict less-than: on ties the lowest index wins.
//  Ineligible candidates (empty class) never update the minimum.
//   If all are ineligible: found=0, best_thr=0, best_sigmaW=0.
//  Gaps: in_valid gaps in RUN are legal; the pipeline advances with bubbles and valids carry through.
//  Arithmetic: all unsigned. Products and sum are full width; no truncation or saturation.
// TESTING
//  T1 NBINS=4; tuples (1,10,1,10),(2,3,1,1),(1,1,1,2),(3,3,3,3)
//     -> sigmaW 20,7,3,18; done pulse; best_thr=2, best_sigmaW=3, found=1.
//  T2 ties: sigmaW 5,5,9,5 -> best_thr=0, best_sigmaW=5.
//  T3 omega0=0 on k=0 and omega1=0 on k=3, others sigmaW 8,6
//     -> best_thr=2, best_sigmaW=6. Then an all-ineligible frame -> found=0, best_sigmaW=0.
//  T4 IW=16, all inputs 16'hFFFF
//     -> best_sigmaW = 2*(16'hFFFF^2) = 33'h1_FFFC_0002 with no overflow.
//  T5 random in_valid gaps and start pulses during RUN
//     -> exactly NBINS accepts, start ignored, result matches a reference model, done pulses once.
//  T6 rst asserted in RUN at k=2 -> all outputs 0 next cycle, no done pulse.
//     Then a fresh frame completes correctly.

Source files
------------

// File: rtl/otsu_sigmaw_argmin_if.sv
// Handshake and result bus between the class-statistics generator and the
// within-class variance argmin block.
interface otsu_sigmaw_argmin_if #(
  parameter int IW    = 16,
  parameter int NBINS = 256,
  parameter int TW    = $clog2(NBINS),
  parameter int OUTW  = 2*IW+1
);
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   omega0;
  logic [IW-1:0]   sigma0_sq;
  logic [IW-1:0]   omega1;
  logic [IW-1:0]   sigma1_sq;
  logic            busy;
  logic            done;
  logic            found;
  logic [TW-1:0]   best_thr;
  logic [OUTW-1:0] best_sigmaW;

  modport master (
    output start, in_valid, omega0, sigma0_sq, omega1, sigma1_sq,
    input  in_ready, busy, done, found, best_thr, best_sigmaW
  );

  modport slave (
    input  start, in_valid, omega0, sigma0_sq, omega1, sigma1_sq,
    output in_ready, busy, done, found, best_thr, best_sigmaW
  );
endinterface

// File: rtl/otsu_sigmaw_argmin.sv
// Pipelined sigmaW_sq = omega0*sigma0_sq + omega1*sigma1_sq per candidate threshold,
// tracking the minimum over NBINS candidates per frame and reporting the winner.
module otsu_sigmaw_argmin #(
  parameter int IW    = 16,
  parameter int NBINS = 256,
  parameter int TW    = $clog2(NBINS),
  parameter int OUTW  = 2*IW+1
) (
  input logic                 clk,
  input logic                 rst,
  otsu_sigmaw_argmin_if.slave bus
);

  localparam int PW = 2*IW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   k_q;
  logic            accept, last_beat, pipe_empty, frame_start;
  logic            in_ready, busy, done;

  logic            s1_v, s1_elig;
  logic [TW-1:0]   s1_idx;
  logic [PW-1:0]   s1_prod0, s1_prod1;

  logic            s2_v, s2_elig;
  logic [TW-1:0]   s2_idx;
  logic [OUTW-1:0] s2_sum;

  logic            s3_v;
  logic [OUTW-1:0] min_q;
  logic [TW-1:0]   best_thr_q;
  logic            found_q;

  assign accept      = bus.in_valid && (state_q == RUN);
  assign last_beat   = (k_q == TW'(NBINS-1));
  assign pipe_empty  = !(s1_v || s2_v || s3_v);
  assign frame_start = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (bus.in_valid && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data registers run freely; only the valid tags need clearing, since every
  // consumer qualifies data with its stage valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      if (frame_start)  k_q <= '0;
      else if (accept)  k_q <= k_q + 1'b1;

      s1_v     <= accept;
      s1_idx   <= k_q;
      s1_elig  <= (bus.omega0 != '0) && (bus.omega1 != '0);
      s1_prod0 <= PW'(bus.omega0) * PW'(bus.sigma0_sq);
      s1_prod1 <= PW'(bus.omega1) * PW'(bus.sigma1_sq);

      s2_v     <= s1_v;
      s2_idx   <= s1_idx;
      s2_elig  <= s1_elig;
      s2_sum   <= {1'b0, s1_prod0} + {1'b0, s1_prod1};

      s3_v     <= s2_v;
    end
  end

  // The min/best registers are the third stage; s3_v keeps DRAIN open until the
  // last comparison has landed. Strict less-than keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q      <= '1;
      best_thr_q <= '0;
      found_q    <= 1'b0;
    end else if (frame_start) begin
      min_q      <= '1;
      best_thr_q <= '0;
      found_q    <= 1'b0;
    end else if (s2_v && s2_elig && (s2_sum < min_q)) begin
      min_q      <= s2_sum;
      best_thr_q <= s2_idx;
      found_q    <= 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.found       = found_q;
  assign bus.best_thr    = best_thr_q;
  assign bus.best_sigmaW = found_q ? min_q : '0;

endmodule
